subtract_mean_hls_deadlock_monitor_gen: RTL and testbench
=========================================================

Name: subtract_mean_hls_deadlock_monitor_gen

Overview:
Parametrised deadlock monitor for an HLS dataflow instance. It watches N AXIS block sources and M sub-instance block/idle pairs. A block condition must persist for a programmable number of consecutive cycles before it is flagged. On detection it records which channel blocked, latches a sticky flag, and counts detection events for debug readback.

Parameters:
NUM_AXIS, 3, number of AXIS block inputs (>=1)
NUM_INST, 4, number of sub-instance idle/block pairs (>=1)
THRESHOLD, 16, consecutive raw-block cycles required to flag (1..2^CNT_W-1)
CNT_W, 8, width of the persistence counter and the event counter
ID_W, 3, width of channel index; must satisfy 2^ID_W >= NUM_AXIS+NUM_INST

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  monitor runs when 1; when 0 the counter holds 0 and block is forced low
clear  in  1  synchronous; clears block_sticky, block_chan_id, event_count
axis_block_sigs  in  NUM_AXIS  per-channel AXIS block indication
axis_mask  in  NUM_AXIS  1 = channel monitored
inst_idle_sigs  in  NUM_INST  sub-instance idle
inst_block_sigs  in  NUM_INST  sub-instance block indication
block  out  1  live deadlock flag (registered)
block_sticky  out  1  set on first detection, held until clear
block_chan_id  out  ID_W  lowest-index source active at first detection
event_count  out  CNT_W  number of IDLE->DETECTED transitions, saturating

Behaviour:
- Reset (reset=0, async): all outputs 0, persistence counter 0, FSM=IDLE.
- src vector (combinational) = {inst_block_sigs & ~inst_idle_sigs, axis_block_sigs & axis_mask}. Axis channel i maps to index i; inst j maps to index NUM_AXIS+j. An idle instance never contributes.
- raw = enable & |src.
- FSM states:
  IDLE: counter 0. If raw=1 and THRESHOLD=1, go to DETECTED. If raw=1 and THRESHOLD>1, go to ARMING with counter=1. Otherwise stay.
  ARMING: if raw=0, go to IDLE and set counter=0. Otherwise counter+1; when counter+1==THRESHOLD, go to DETECTED.
  DETECTED: block=1. On raw=0, go to IDLE and clear the counter; block drops the next cycle.
- block is registered and equals (state==DETECTED).
- Latency: raw goes high before edge k and stays high, so block is 1 after edge k+THRESHOLD-1. With THRESHOLD=1, block rises one cycle after raw, and falls one cycle after raw drops.
- Any single low cycle of raw restarts the count; no hysteresis.
- On each entry to DETECTED:
  - event_count increments, saturating at 2^CNT_W-1.
  - If block_sticky was 0, block_chan_id is loaded with the priority-encoded lowest set index of src on that cycle, and block_sticky is set.
  - Later detections do not change block_chan_id.
- clear:
  - Zeroes block_sticky, block_chan_id and event_count next edge. Does not affect FSM, counter or block.
  - If clear and a DETECTED entry occur on the same edge, the entry wins: sticky=1, id=new source, event_count=1.
- enable=0: FSM forced to IDLE, counter 0, block 0 next edge. Sticky, id and count are held.
- Async reset mid-ARMING or mid-DETECTED: immediate return to the reset state.

Test Plan:
- THRESHOLD=1, axis_mask=3'b111, drive axis_block_sigs=3'b010 for 1 cycle -> block high exactly 1 cycle, one edge later; block_chan_id=1, event_count=1, sticky=1.
- THRESHOLD=16, hold axis_block_sigs[0] for 15 cycles, drop 1 cycle, then hold 16 cycles -> no block on the first burst; block asserts after the 16th cycle of the second burst; event_count=1.
- inst_block_sigs=4'b0100 with inst_idle_sigs=4'b0100 for 40 cycles -> block never asserts. Then idle[2]=0 -> block after 16 cycles, block_chan_id=5.
- axis_mask=3'b000, axis_block_sigs=3'b111 -> no detection. Then simultaneous axis[2] and inst[0] blocking -> block_chan_id=2 (lowest index).
- Two detections, then clear pulsed on the same edge as a third DETECTED entry from inst[3] -> sticky=1, block_chan_id=6, event_count=1.
- Drive reset low while in DETECTED -> block, sticky, id and count are 0 immediately (asynchronous). CNT_W=2 with 5 detections -> event_count saturates at 3.

Source files
------------

// File: rtl/subtract_mean_hls_deadlock_monitor_gen_if.sv
// Handshake bundle between the deadlock monitor and its environment.
// The environment drives control and the raw block/idle sources (master).
// The monitor returns the live flag and the debug capture (slave).
interface subtract_mean_hls_deadlock_monitor_gen_if #(
  parameter int NUM_AXIS = 3,
  parameter int NUM_INST = 4,
  parameter int CNT_W    = 8,
  parameter int ID_W     = 3
);
  logic                enable;
  logic                clear;
  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic [NUM_AXIS-1:0] axis_mask;
  logic [NUM_INST-1:0] inst_idle_sigs;
  logic [NUM_INST-1:0] inst_block_sigs;
  logic                block;
  logic                block_sticky;
  logic [ID_W-1:0]     block_chan_id;
  logic [CNT_W-1:0]    event_count;

  modport master (
    output enable, clear, axis_block_sigs, axis_mask, inst_idle_sigs, inst_block_sigs,
    input  block, block_sticky, block_chan_id, event_count
  );

  modport slave (
    input  enable, clear, axis_block_sigs, axis_mask, inst_idle_sigs, inst_block_sigs,
    output block, block_sticky, block_chan_id, event_count
  );
endinterface

// File: rtl/subtract_mean_hls_deadlock_monitor_gen.sv
// Deadlock monitor for an HLS dataflow instance.
// A block condition from any monitored source must persist for THRESHOLD
// consecutive cycles before the live flag rises. The first detection after
// a clear captures the lowest-index blocking source; every detection bumps
// a saturating event counter.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | no block seen, persistence counter 0
// ST_ARMING   | raw block seen for cnt_q consecutive cycles (< THRESHOLD)
// ST_DETECTED | block persisted THRESHOLD cycles, live flag asserted
module subtract_mean_hls_deadlock_monitor_gen #(
  parameter int NUM_AXIS  = 3,
  parameter int NUM_INST  = 4,
  parameter int THRESHOLD = 16,
  parameter int CNT_W     = 8,
  parameter int ID_W      = 3
) (
  input logic clock,
  input logic reset,
  subtract_mean_hls_deadlock_monitor_gen_if.slave mon
);

  localparam int NSRC = NUM_AXIS + NUM_INST;
  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMING   = 2'd1,
    ST_DETECTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             block_q;
  logic             sticky_q;
  logic [ID_W-1:0]  id_q;
  logic [CNT_W-1:0] evt_q;

  logic [NSRC-1:0]  src;
  logic             raw;
  logic [ID_W-1:0]  enc;
  logic             entry;

  // An idle instance never counts as blocked; axis channels only when masked in.
  assign src = {mon.inst_block_sigs & ~mon.inst_idle_sigs,
                mon.axis_block_sigs & mon.axis_mask};
  assign raw = mon.enable & (|src);

  // Lowest set index of src wins.
  always_comb begin
    enc = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src[i]) enc = ID_W'(i);
    end
  end

  // Next-state and persistence counter; enable=0 drops raw, which walks every state to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (raw) begin
          if (THRESHOLD == 1) begin
            state_d = ST_DETECTED;
          end else begin
            state_d = ST_ARMING;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_ARMING: begin
        if (!raw) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if ((cnt_q + 1'b1) == THR) state_d = ST_DETECTED;
        end
      end
      ST_DETECTED: begin
        if (!raw) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign entry = (state_d == ST_DETECTED) && (state_q != ST_DETECTED);

  // FSM state, counter and the registered live flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      block_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      block_q <= (state_d == ST_DETECTED);
    end
  end

  // Debug capture; a detection entry overrides a coincident clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sticky_q <= 1'b0;
      id_q     <= '0;
      evt_q    <= '0;
    end else if (entry) begin
      if (mon.clear) begin
        sticky_q <= 1'b1;
        id_q     <= enc;
        evt_q    <= CNT_W'(1);
      end else begin
        if (evt_q != '1) evt_q <= evt_q + 1'b1;
        if (!sticky_q) begin
          sticky_q <= 1'b1;
          id_q     <= enc;
        end
      end
    end else if (mon.clear) begin
      sticky_q <= 1'b0;
      id_q     <= '0;
      evt_q    <= '0;
    end
  end

  assign mon.block         = block_q;
  assign mon.block_sticky  = sticky_q;
  assign mon.block_chan_id = id_q;
  assign mon.event_count   = evt_q;

endmodule

// File: tb/tb_subtract_mean_hls_deadlock_monitor_gen.sv
// Directed bench for the deadlock monitor. Three instances share one
// stimulus: A (THRESHOLD=1), B (THRESHOLD=16) and C (THRESHOLD=2, CNT_W=2).
// Expectations are queued before the clock steps and drained afterwards.
module tb_subtract_mean_hls_deadlock_monitor_gen;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       clear;
  logic [2:0] axis_block_sigs;
  logic [2:0] axis_mask;
  logic [3:0] inst_idle_sigs;
  logic [3:0] inst_block_sigs;

  int tests = 0;
  int fails = 0;

  subtract_mean_hls_deadlock_monitor_gen_if #(.CNT_W(8)) if_a ();
  subtract_mean_hls_deadlock_monitor_gen_if #(.CNT_W(8)) if_b ();
  subtract_mean_hls_deadlock_monitor_gen_if #(.CNT_W(2)) if_c ();

  assign if_a.enable = enable;          assign if_b.enable = enable;          assign if_c.enable = enable;
  assign if_a.clear  = clear;           assign if_b.clear  = clear;           assign if_c.clear  = clear;
  assign if_a.axis_block_sigs = axis_block_sigs;
  assign if_b.axis_block_sigs = axis_block_sigs;
  assign if_c.axis_block_sigs = axis_block_sigs;
  assign if_a.axis_mask = axis_mask;    assign if_b.axis_mask = axis_mask;    assign if_c.axis_mask = axis_mask;
  assign if_a.inst_idle_sigs = inst_idle_sigs;
  assign if_b.inst_idle_sigs = inst_idle_sigs;
  assign if_c.inst_idle_sigs = inst_idle_sigs;
  assign if_a.inst_block_sigs = inst_block_sigs;
  assign if_b.inst_block_sigs = inst_block_sigs;
  assign if_c.inst_block_sigs = inst_block_sigs;

  subtract_mean_hls_deadlock_monitor_gen #(.THRESHOLD(1), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .mon(if_a.slave));
  subtract_mean_hls_deadlock_monitor_gen #(.THRESHOLD(16), .CNT_W(8)) dut_b (
    .clock(clock), .reset(reset), .mon(if_b.slave));
  subtract_mean_hls_deadlock_monitor_gen #(.THRESHOLD(2), .CNT_W(2)) dut_c (
    .clock(clock), .reset(reset), .mon(if_c.slave));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // m: field mask {block, sticky, id, count}
  typedef struct {
    int         sel;
    logic [3:0] m;
    logic       b;
    logic       s;
    logic [2:0] id;
    logic [7:0] c;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic cmp(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [3:0] m,
                      input logic b, input logic s, input logic [2:0] id, input logic [7:0] c);
    exp_t e;
    e.sel = sel; e.m = m; e.b = b; e.s = s; e.id = id; e.c = c;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    exp_t       e;
    string      t;
    logic       ob, os;
    logic [2:0] oid;
    logic [7:0] oc;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      case (e.sel)
        0: begin ob = if_a.block; os = if_a.block_sticky; oid = if_a.block_chan_id; oc = if_a.event_count; end
        1: begin ob = if_b.block; os = if_b.block_sticky; oid = if_b.block_chan_id; oc = if_b.event_count; end
        default: begin ob = if_c.block; os = if_c.block_sticky; oid = if_c.block_chan_id; oc = {6'd0, if_c.event_count}; end
      endcase
      if (e.m[3]) cmp(t, "block",  {7'd0, ob}, {7'd0, e.b});
      if (e.m[2]) cmp(t, "sticky", {7'd0, os}, {7'd0, e.s});
      if (e.m[1]) cmp(t, "chan_id", {5'd0, oid}, {5'd0, e.id});
      if (e.m[0]) cmp(t, "evt_cnt", oc, e.c);
    end
  endtask

  // Queue an expectation, advance n cycles, then compare.
  task automatic step(input int n, input string tag, input int sel, input logic [3:0] m,
                      input logic b, input logic s, input logic [2:0] id, input logic [7:0] c);
    push(tag, sel, m, b, s, id, c);
    cyc(n);
    drain();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; clear = 1'b0;
    axis_block_sigs = '0; axis_mask = '0; inst_idle_sigs = '0; inst_block_sigs = '0;
    #12;
    step(0, "rst_a", 0, 4'hF, 0, 0, 0, 0);
    step(0, "rst_b", 1, 4'hF, 0, 0, 0, 0);
    step(0, "rst_c", 2, 4'hF, 0, 0, 0, 0);
    reset = 1'b1;
    cyc(1);

    // THRESHOLD=1: one-cycle block on axis[1]
    enable = 1'b1; axis_mask = 3'b111; axis_block_sigs = 3'b010;
    step(1, "t1_rise", 0, 4'hF, 1, 1, 1, 1);
    axis_block_sigs = 3'b000;
    step(1, "t1_fall", 0, 4'hF, 0, 1, 1, 1);

    // THRESHOLD=16: 15-cycle burst, gap, 16-cycle burst
    axis_block_sigs = 3'b001;
    step(15, "t16_burst15", 1, 4'hF, 0, 0, 0, 0);
    axis_block_sigs = 3'b000;
    step(1, "t16_gap", 1, 4'h8, 0, 0, 0, 0);
    axis_block_sigs = 3'b001;
    step(15, "t16_c15", 1, 4'h8, 0, 0, 0, 0);
    step(1, "t16_c16", 1, 4'hF, 1, 1, 0, 1);
    axis_block_sigs = 3'b000;
    step(1, "t16_drop", 1, 4'hF, 0, 1, 0, 1);

    // Idle instance never blocks; then inst[2] goes active
    pulse_clear();
    push("clr1", 1, 4'hF, 0, 0, 0, 0); drain();
    inst_block_sigs = 4'b0100; inst_idle_sigs = 4'b0100;
    step(40, "idle_inst", 1, 4'hF, 0, 0, 0, 0);
    inst_idle_sigs = 4'b0000;
    step(15, "inst2_c15", 1, 4'h8, 0, 0, 0, 0);
    step(1, "inst2_c16", 1, 4'hF, 1, 1, 5, 1);

    // enable=0 drops block next edge, holds capture; re-detection keeps id
    enable = 1'b0;
    step(1, "en_off", 1, 4'hF, 0, 1, 5, 1);
    enable = 1'b1;
    step(15, "en_c15", 1, 4'h8, 0, 0, 0, 0);
    step(1, "en_c16", 1, 4'hF, 1, 1, 5, 2);
    inst_block_sigs = 4'b0000;
    step(1, "en_drop", 1, 4'h8, 0, 0, 0, 0);

    // Masked-out axis; then axis[2] and inst[0] together
    pulse_clear();
    axis_mask = 3'b000; axis_block_sigs = 3'b111;
    step(20, "masked", 1, 4'hF, 0, 0, 0, 0);
    axis_mask = 3'b111; axis_block_sigs = 3'b100; inst_block_sigs = 4'b0001;
    step(15, "prio_c15", 1, 4'h8, 0, 0, 0, 0);
    step(1, "prio_c16", 1, 4'hF, 1, 1, 2, 1);
    axis_block_sigs = 3'b000; inst_block_sigs = 4'b0000;
    step(1, "prio_drop", 1, 4'h8, 0, 0, 0, 0);

    // Two detections, then clear coincident with a third entry from inst[3]
    pulse_clear();
    for (int k = 0; k < 2; k++) begin
      axis_block_sigs = 3'b010;
      cyc(16);
      axis_block_sigs = 3'b000;
      cyc(1);
    end
    step(0, "two_det", 1, 4'hF, 0, 1, 1, 2);
    inst_block_sigs = 4'b1000;
    cyc(15);
    clear = 1'b1;
    step(1, "clr_vs_entry", 1, 4'hF, 1, 1, 6, 1);
    clear = 1'b0;
    step(1, "post_entry", 1, 4'hF, 1, 1, 6, 1);

    // Asynchronous reset while detected
    reset = 1'b0;
    #1;
    step(0, "async_rst", 1, 4'hF, 0, 0, 0, 0);
    inst_block_sigs = 4'b0000;
    #2;
    reset = 1'b1;
    cyc(1);

    // CNT_W=2, THRESHOLD=2: event counter saturates at 3
    pulse_clear();
    for (int k = 0; k < 5; k++) begin
      axis_block_sigs = 3'b001;
      cyc(2);
      axis_block_sigs = 3'b000;
      cyc(1);
      if (k == 1) step(0, "sat_2", 2, 4'hF, 0, 1, 0, 2);
      if (k == 2) step(0, "sat_3", 2, 4'h1, 0, 0, 0, 3);
    end
    step(0, "sat_5", 2, 4'hF, 0, 1, 0, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
